frame_serializer: RTL and testbench

//  Transmit end of the 10-bit sideband link: accepts one WIDTH-bit word per valid/ready handshake and sends it
//  LSB-first as an asynchronous serial frame (start, data, optional parity, stop). It drives the frame that the

---
 rtl/frame_serializer_pkg.sv | 20 ++
 rtl/frame_serializer_if.sv | 39 +++
 rtl/frame_bit_timer.sv | 32 +++
 rtl/frame_serializer.sv | 155 +++++++++++++++
 tb/tb_frame_serializer.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/frame_serializer_pkg.sv
// rtl/frame_serializer_pkg.sv - shared state type and counter sizing for the frame serializer
package frame_serializer_pkg;

  // Frame states; the parity state only exists when parity is built in
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef DEFINE_A
    PARITY,
`endif
    STOP
  } state_t;

  // Width of a counter that must hold 0..n-1, never narrower than one bit
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/frame_serializer_if.sv
// rtl/frame_serializer_if.sv - word handshake and serial line bundle for the frame serializer
interface frame_serializer_if #(
  parameter int WIDTH = 10
);

  logic             i_valid;
  logic             o_ready;
  logic [WIDTH-1:0] i_data;
  logic             o_serial;
  logic             o_busy;
`ifdef DEFINE_A
  logic             o_frame_done;
`endif

  // Word source and line observer side
  modport master (
    output i_valid,
    output i_data,
    input  o_ready,
    input  o_serial,
    input  o_busy
`ifdef DEFINE_A
    , input o_frame_done
`endif
  );

  // Serializer side
  modport slave (
    input  i_valid,
    input  i_data,
    output o_ready,
    output o_serial,
    output o_busy
`ifdef DEFINE_A
    , output o_frame_done
`endif
  );

endinterface

// File: rtl/frame_bit_timer.sv
// rtl/frame_bit_timer.sv - counts clocks within one serial bit and strobes the last one
module frame_bit_timer
  import frame_serializer_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic clear,
  output logic bit_end
);

  localparam int CW = cnt_width(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  // Strobe is high for the final clock of every bit
  assign bit_end = (cnt == LAST);

  // Counter held at zero while cleared, wraps to zero at the end of each bit
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      cnt <= '0;
    end else if (clear || bit_end) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/frame_serializer.sv
// rtl/frame_serializer.sv - sends one handshaked word per frame as LSB-first async serial
module frame_serializer
  import frame_serializer_pkg::*;
#(
  parameter int WIDTH        = 10,
  parameter int CLKS_PER_BIT = 4,
  parameter int STOP_BITS    = 1
`ifdef DEFINE_A
  , parameter int ODD_PARITY = 0
`endif
) (
  input  logic              i_clk,
  input  logic              i_rst,
  frame_serializer_if.slave bus
);

  localparam int IW = cnt_width(WIDTH);
  localparam int SW = cnt_width(STOP_BITS);
  localparam logic [IW-1:0] IDX_LAST  = IW'(WIDTH - 1);
  localparam logic [SW-1:0] STOP_LAST = SW'(STOP_BITS - 1);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] shift_next;
  logic [IW-1:0]    idx;
  logic [IW-1:0]    idx_next;
  logic [SW-1:0]    stop_idx;
  logic [SW-1:0]    stop_next;
  logic             serial_next;
  logic             bit_end;
  logic             timer_clear;
  logic             transfer;

  // Handshake uses the registered ready so a word is never taken during the first post-reset cycle
  assign transfer    = bus.i_valid && bus.o_ready;
  // The bit timer restarts from zero for every frame
  assign timer_clear = (state == IDLE);

  frame_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_bit_timer (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .clear   (timer_clear),
    .bit_end (bit_end)
  );

`ifdef DEFINE_A
  logic parity_q;

  // Parity captured with the word so it stays stable while the word shifts out
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      parity_q <= 1'b0;
    end else if (transfer) begin
      parity_q <= (^bus.i_data) ^ 1'(ODD_PARITY);
    end
  end

  // Pulse in the final clock of the final stop bit
  assign bus.o_frame_done = (state == STOP) && bit_end && (stop_idx == STOP_LAST);
`endif

  // State, datapath and registered line outputs
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state        <= IDLE;
      shift_reg    <= '0;
      idx          <= '0;
      stop_idx     <= '0;
      bus.o_serial <= 1'b1;
      bus.o_ready  <= 1'b0;
      bus.o_busy   <= 1'b0;
    end else begin
      state        <= state_next;
      shift_reg    <= shift_next;
      idx          <= idx_next;
      stop_idx     <= stop_next;
      bus.o_serial <= serial_next;
      bus.o_ready  <= (state_next == IDLE);
      bus.o_busy   <= (state_next != IDLE);
    end
  end

  // Next state, next datapath values and the line level for the next cycle
  always_comb begin
    state_next  = state;
    shift_next  = shift_reg;
    idx_next    = idx;
    stop_next   = stop_idx;
    serial_next = 1'b1;

    case (state)
      IDLE: begin
        if (transfer) begin
          state_next = START;
          shift_next = bus.i_data;
          idx_next   = '0;
          stop_next  = '0;
        end
      end
      START: begin
        if (bit_end) begin
          state_next = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_next = shift_reg >> 1;
          if (idx == IDX_LAST) begin
            idx_next = '0;
`ifdef DEFINE_A
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end else begin
            idx_next = idx + 1'b1;
          end
        end
      end
`ifdef DEFINE_A
      PARITY: begin
        if (bit_end) begin
          state_next = STOP;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          if (stop_idx == STOP_LAST) begin
            state_next = IDLE;
            stop_next  = '0;
          end else begin
            stop_next = stop_idx + 1'b1;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    case (state_next)
      START:   serial_next = 1'b0;
      DATA:    serial_next = shift_next[0];
`ifdef DEFINE_A
      PARITY:  serial_next = parity_q;
`endif
      default: serial_next = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_frame_serializer.sv
// tb/tb_frame_serializer.sv - directed self-checking bench for frame_serializer
module tb_frame_serializer;

`ifdef DEFINE_A
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int N_A = 4 * (1 + 10 + P + 1);
  localparam int N_B = 1 * (1 + 10 + P + 2);

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  frame_serializer_if #(.WIDTH(10)) bus_a ();
  frame_serializer_if #(.WIDTH(10)) bus_b ();

  frame_serializer #(
    .WIDTH        (10),
    .CLKS_PER_BIT (4),
    .STOP_BITS    (1)
  ) dut_a (
    .i_clk (clk),
    .i_rst (rst_n),
    .bus   (bus_a)
  );

  frame_serializer #(
    .WIDTH        (10),
    .CLKS_PER_BIT (1),
    .STOP_BITS    (2)
  ) dut_b (
    .i_clk (clk),
    .i_rst (rst_n),
    .bus   (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic obs_serial(input int sel);
    return (sel != 0) ? bus_b.o_serial : bus_a.o_serial;
  endfunction

  function automatic logic obs_busy(input int sel);
    return (sel != 0) ? bus_b.o_busy : bus_a.o_busy;
  endfunction

  function automatic logic obs_ready(input int sel);
    return (sel != 0) ? bus_b.o_ready : bus_a.o_ready;
  endfunction

`ifdef DEFINE_A
  function automatic logic obs_done(input int sel);
    return (sel != 0) ? bus_b.o_frame_done : bus_a.o_frame_done;
  endfunction
`endif

  // Expected line level during serial bit k of a frame carrying d (even parity)
  function automatic logic exp_bit(input logic [9:0] d, input int k);
    if (k == 0) return 1'b0;
    if (k <= 10) return d[k-1];
`ifdef DEFINE_A
    if (k == 11) return ^d;
`endif
    return 1'b1;
  endfunction

  // Checks frame cycles 1..ncyc; entered #1 after the edge that started cycle 1
  task automatic run_frame(input int sel, input logic [9:0] d, input int ncyc, input string tag);
    int cpb;
    int n;
    cpb = (sel != 0) ? 1 : 4;
    n   = (sel != 0) ? N_B : N_A;
    for (int c = 1; c <= ncyc; c++) begin
      chk($sformatf("%s_serial_c%0d", tag, c), 32'(obs_serial(sel)), 32'(exp_bit(d, (c - 1) / cpb)));
      chk($sformatf("%s_busy_c%0d", tag, c), 32'(obs_busy(sel)), 32'd1);
      chk($sformatf("%s_ready_c%0d", tag, c), 32'(obs_ready(sel)), 32'd0);
`ifdef DEFINE_A
      chk($sformatf("%s_done_c%0d", tag, c), 32'(obs_done(sel)), 32'(c == n));
`endif
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_idle(input int sel, input string tag);
    chk({tag, "_idle_serial"}, 32'(obs_serial(sel)), 32'd1);
    chk({tag, "_idle_busy"}, 32'(obs_busy(sel)), 32'd0);
    chk({tag, "_idle_ready"}, 32'(obs_ready(sel)), 32'd1);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n = 1'b0;
    bus_a.i_valid = 1'b1;
    bus_a.i_data  = 10'h2A5;
    bus_b.i_valid = 1'b0;
    bus_b.i_data  = 10'h000;

    // Reset held with valid asserted
    repeat (3) @(posedge clk);
    #1;
    chk("rst_serial_a", 32'(bus_a.o_serial), 32'd1);
    chk("rst_busy_a", 32'(bus_a.o_busy), 32'd0);
    chk("rst_ready_a", 32'(bus_a.o_ready), 32'd0);
    chk("rst_ready_b", 32'(bus_b.o_ready), 32'd0);
    rst_n = 1'b1;
    chk("rel_ready_a_same", 32'(bus_a.o_ready), 32'd0);
    @(posedge clk);
    #1;
    chk_idle(0, "rel_a");
    chk_idle(1, "rel_b");

    // Single word 2A5, valid still held from reset
    @(posedge clk);
    #1;
    bus_a.i_valid = 1'b0;
    run_frame(0, 10'h2A5, N_A, "w2a5");
    chk_idle(0, "w2a5");

    // Back-to-back with valid held and data changed mid-frame
    bus_a.i_valid = 1'b1;
    bus_a.i_data  = 10'h3FF;
    @(posedge clk);
    #1;
    bus_a.i_data = 10'h000;
    run_frame(0, 10'h3FF, N_A, "b2b_3ff");
    chk_idle(0, "b2b_gap");
    @(posedge clk);
    #1;
    bus_a.i_valid = 1'b0;
    bus_a.i_data  = 10'h155;
    run_frame(0, 10'h000, N_A, "b2b_000");
    chk_idle(0, "b2b_end");

    // Reset in the middle of data bit 4
    bus_a.i_valid = 1'b1;
    bus_a.i_data  = 10'h2A5;
    @(posedge clk);
    #1;
    bus_a.i_valid = 1'b0;
    run_frame(0, 10'h2A5, 21, "mid");
    chk("mid_bit4_serial", 32'(bus_a.o_serial), 32'd0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_serial", 32'(bus_a.o_serial), 32'd1);
    chk("mid_rst_busy", 32'(bus_a.o_busy), 32'd0);
    chk("mid_rst_ready", 32'(bus_a.o_ready), 32'd0);
`ifdef DEFINE_A
    chk("mid_rst_done", 32'(bus_a.o_frame_done), 32'd0);
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_idle(0, "mid_rel");
    bus_a.i_valid = 1'b1;
    bus_a.i_data  = 10'h135;
    @(posedge clk);
    #1;
    bus_a.i_valid = 1'b0;
    run_frame(0, 10'h135, N_A, "after_rst");
    chk_idle(0, "after_rst");

    // Two stop bits at one clock per bit
    bus_b.i_valid = 1'b1;
    bus_b.i_data  = 10'h0F3;
    @(posedge clk);
    #1;
    bus_b.i_valid = 1'b0;
    run_frame(1, 10'h0F3, N_B, "stop2");
    chk_idle(1, "stop2");
    chk("a_quiet_serial", 32'(bus_a.o_serial), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
